refresh_scheduler: RTL and testbench
====================================

REFRESH_SCHEDULER -- requirements
Module: refresh_scheduler

Interface
REQ-001 SHALL have parameter INTERVAL, default 5: ECLK cycles per owed refresh (5 x ~1.4 us = ~7.1 us).
REQ-002 SHALL have parameter MAX_DEBT, default 8: saturation limit of owed refreshes.
REQ-003 SHALL have parameter URGENT_LEVEL, default 6: debt at or above which refresh is urgent.
REQ-004 SHALL have port ECLK  in  1  clock.
REQ-005 SHALL have port refreshreset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  in  1  SDRAM init complete; comes from the CLK domain and is synchronised internally.
REQ-007 SHALL have port ack_toggle  in  1  from the CLK-domain controller; flips once per completed auto-refresh.
REQ-008 SHALL have port refresh_req  out  1  level request; high while debt>0 and the state is not DISABLED.
REQ-009 SHALL have port refresh_urgent  out  1  high in the URGENT state.
REQ-010 SHALL have port debt  out  4  current owed-refresh count, 0..MAX_DEBT.
REQ-011 SHALL have port overflow  out  1  sticky; a refresh was lost to saturation.

Function
REQ-012 SHALL pass enable through a 2-flop synchroniser (en_s1, en_s2).
REQ-013 SHALL pass ack_toggle through a 2-flop synchroniser (ak_s1, ak_s2) plus a history flop ak_prev.
REQ-014 SHALL generate ack_pulse = ak_s2 XOR ak_prev, evaluated each ECLK; ak_prev <= ak_s2 every cycle in all states.
REQ-015 Latency: an ack_toggle flip SHALL change debt on the 3rd ECLK rising edge after the flip is sampled.
REQ-016 SHALL have an interval down-counter (width ceil(log2(INTERVAL))) that reloads to INTERVAL-1; tick = counter==0 while not DISABLED.
REQ-017 On tick, the counter SHALL reload to INTERVAL-1; otherwise it decrements; it holds at INTERVAL-1 in DISABLED.
REQ-018 SHALL have 4 FSM states: DISABLED, IDLE (debt=0), PENDING (0<debt<URGENT_LEVEL), URGENT (debt>=URGENT_LEVEL).
REQ-019 DISABLED->IDLE SHALL occur when en_s2=1; any state->DISABLED when en_s2=0; debt and overflow hold while DISABLED.
REQ-020 In DISABLED, ack_pulse SHALL be discarded; this absorbs the false edge from a post-reset ack_toggle=1.
REQ-021 Outside DISABLED, the next debt SHALL be computed from (tick, ack_pulse) as follows:
 - tick only: debt+1, saturating at MAX_DEBT; a tick at MAX_DEBT sets overflow.
 - ack only: debt-1; an ack at debt=0 is ignored and debt stays 0.
 - both: debt unchanged, including at MAX_DEBT (no overflow) and at 0.
REQ-022 IDLE/PENDING/URGENT SHALL be re-derived each cycle from the next debt value; transitions may skip states only via saturation rules, never by more than 1 count per cycle.
REQ-023 Outputs SHALL be registered; debt, refresh_req and refresh_urgent SHALL update on the same edge as the state.
REQ-024 overflow SHALL clear only on reset.
REQ-025 All arithmetic SHALL be unsigned 4-bit; debt SHALL never exceed MAX_DEBT or go negative.

Reset
REQ-026 refreshreset low SHALL asynchronously set: state DISABLED, counter INTERVAL-1, debt 0, refresh_req 0, refresh_urgent 0, overflow 0, all synchroniser and history flops 0.
REQ-027 Reset asserted mid-operation SHALL discard pending debt, and discard in-flight acks after release.
REQ-028 After refreshreset release, the first tick SHALL occur no earlier than INTERVAL ECLK cycles after entering IDLE.

Verification
REQ-029 Reset release with enable=1, no acks -> IDLE at edge 3; debt=1 and refresh_req=1 at edge 3+5=8; debt=2 at edge 13.
REQ-030 Reset with ack_toggle held 1, enable=1 -> debt stays 0 and no decrement occurs; the false edge is discarded in DISABLED.
REQ-031 debt=3, ack_toggle flipped once -> debt=2 exactly 3 edges later; a second flip 1 cycle after the first -> debt=1 the next edge.
REQ-032 No acks for 50 ticks -> debt climbs through 5 (PENDING) to 6 (refresh_urgent=1) to 8; the next tick sets overflow=1 while debt stays 8.
REQ-033 debt=8, tick and ack_pulse coincide -> debt=8, overflow stays 0; debt=0 with ack only -> debt stays 0.
REQ-034 debt=4, enable dropped -> DISABLED, refresh_req=0, debt holds 4, counter frozen; enable raised -> PENDING, refresh_req=1 two edges after sync.

Source files
------------

// File: rtl/refresh_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : refresh_scheduler
//  Purpose  : Tracks SDRAM auto-refreshes that are owed. An interval timer
//             adds one unit of debt every INTERVAL ECLK cycles. Each completed
//             refresh, reported by the controller as a toggle, removes one.
//             The block raises a request while debt is owed, and raises an
//             urgent flag once debt reaches URGENT_LEVEL. Debt saturates at
//             MAX_DEBT, and a lost refresh sets a sticky overflow flag.
//  Ports    : ECLK           - scheduler clock
//             refreshreset   - asynchronous, active-low reset
//             enable         - SDRAM init complete (CLK domain, synchronised)
//             ack_toggle     - flips once per completed refresh (CLK domain)
//             refresh_req    - level request, debt > 0 while enabled
//             refresh_urgent - high while debt >= URGENT_LEVEL
//             debt           - owed refresh count, 0..MAX_DEBT
//             overflow       - sticky, a refresh was lost to saturation
//  Revision : 1.0 - initial release
// ============================================================================
module refresh_scheduler #(
    parameter int unsigned INTERVAL     = 5,
    parameter int unsigned MAX_DEBT     = 8,
    parameter int unsigned URGENT_LEVEL = 6
) (
    input  logic       ECLK,
    input  logic       refreshreset,
    input  logic       enable,
    input  logic       ack_toggle,
    output logic       refresh_req,
    output logic       refresh_urgent,
    output logic [3:0] debt,
    output logic       overflow
);

    // A one-cycle interval still needs a one-bit counter to exist.
    localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    localparam logic [CW-1:0] c_reload = CW'(INTERVAL - 1);
    localparam logic [3:0]    c_max    = 4'(MAX_DEBT);
    localparam logic [3:0]    c_urgent = 4'(URGENT_LEVEL);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_PENDING  = 2'd2,
        ST_URGENT   = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic            r_en_s1;
    logic            r_en_s2;
    logic            r_ak_s1;
    logic            r_ak_s2;
    logic            r_ak_prev;

    logic            w_ack_pulse;
    logic            w_tick;
    logic [3:0]      w_debt_nxt;
    logic            w_ovf_set;

    // Any edge on the synchronised toggle is one completed refresh.
    assign w_ack_pulse = r_ak_s2 ^ r_ak_prev;
    assign w_tick      = (r_state != ST_DISABLED) && (r_count == '0);

    // Debt arithmetic for the active states. A coincident tick and ack
    // cancel, so a tick at saturation that is offset by an ack does not
    // count as a lost refresh.
    always_comb begin
        w_debt_nxt = debt;
        w_ovf_set  = 1'b0;
        case ({w_tick, w_ack_pulse})
            2'b10: begin
                if (debt >= c_max) begin
                    w_debt_nxt = c_max;
                    w_ovf_set  = 1'b1;
                end else begin
                    w_debt_nxt = debt + 4'd1;
                end
            end
            2'b01: begin
                if (debt != 4'd0) begin
                    w_debt_nxt = debt - 4'd1;
                end
            end
            default: begin
                w_debt_nxt = debt;
            end
        endcase
    end

    function automatic state_t state_of(input logic [3:0] d);
        if (d == 4'd0) begin
            return ST_IDLE;
        end else if (d >= c_urgent) begin
            return ST_URGENT;
        end else begin
            return ST_PENDING;
        end
    endfunction

    always_ff @(posedge ECLK or negedge refreshreset) begin
        if (!refreshreset) begin
            r_state        <= ST_DISABLED;
            r_count        <= c_reload;
            r_en_s1        <= 1'b0;
            r_en_s2        <= 1'b0;
            r_ak_s1        <= 1'b0;
            r_ak_s2        <= 1'b0;
            r_ak_prev      <= 1'b0;
            debt           <= 4'd0;
            refresh_req    <= 1'b0;
            refresh_urgent <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            r_en_s1   <= enable;
            r_en_s2   <= r_en_s1;
            r_ak_s1   <= ack_toggle;
            r_ak_s2   <= r_ak_s1;
            // The history flop advances even while disabled. This consumes
            // any toggle edge seen there, including the spurious edge from
            // an ack_toggle that was already high out of reset.
            r_ak_prev <= r_ak_s2;

            if (r_state == ST_DISABLED) begin
                r_count <= c_reload;
                if (r_en_s2) begin
                    // Debt retained from before the disable picks the state.
                    r_state        <= state_of(debt);
                    refresh_req    <= (debt != 4'd0);
                    refresh_urgent <= (debt >= c_urgent);
                end
            end else if (!r_en_s2) begin
                r_state        <= ST_DISABLED;
                r_count        <= c_reload;
                refresh_req    <= 1'b0;
                refresh_urgent <= 1'b0;
            end else begin
                r_count        <= w_tick ? c_reload : (r_count - CW'(1));
                debt           <= w_debt_nxt;
                overflow       <= overflow | w_ovf_set;
                r_state        <= state_of(w_debt_nxt);
                refresh_req    <= (w_debt_nxt != 4'd0);
                refresh_urgent <= (w_debt_nxt >= c_urgent);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_refresh_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_refresh_scheduler
//  Purpose  : Randomised self-checking bench for refresh_scheduler. A
//             behavioural model predicts the outputs after every ECLK edge and
//             queues them. A monitor compares each queued entry with the DUT
//             on the following falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_refresh_scheduler;

    localparam int INTERVAL     = 5;
    localparam int MAX_DEBT     = 8;
    localparam int URGENT_LEVEL = 6;

    logic       ECLK         = 1'b0;
    logic       refreshreset = 1'b0;
    logic       enable       = 1'b0;
    logic       ack_toggle   = 1'b0;
    logic       refresh_req;
    logic       refresh_urgent;
    logic [3:0] debt;
    logic       overflow;

    refresh_scheduler #(
        .INTERVAL     (INTERVAL),
        .MAX_DEBT     (MAX_DEBT),
        .URGENT_LEVEL (URGENT_LEVEL)
    ) dut (
        .ECLK           (ECLK),
        .refreshreset   (refreshreset),
        .enable         (enable),
        .ack_toggle     (ack_toggle),
        .refresh_req    (refresh_req),
        .refresh_urgent (refresh_urgent),
        .debt           (debt),
        .overflow       (overflow)
    );

    always #5 ECLK = ~ECLK;

    typedef struct packed {
        logic       req;
        logic       urg;
        logic       ovf;
        logic [3:0] debt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   stim_done = 1'b0;

    // ------------------------------------------------------------------
    // Reference model. The inputs are seen two edges late, so the model
    // keeps a short history of the raw samples. An ack counts when the
    // delayed toggle samples differ. A tick falls every INTERVAL-th
    // active edge after the block becomes enabled.
    // ------------------------------------------------------------------
    bit m_active;
    int m_debt;
    bit m_ovf;
    int m_phase;
    bit a_hist[$];
    bit e_hist[$];

    task automatic model_step();
        bit   en_eff;
        bit   pulse;
        bit   tick;
        exp_t e;
        if (!refreshreset) begin
            m_active = 1'b0;
            m_debt   = 0;
            m_ovf    = 1'b0;
            m_phase  = 0;
            a_hist   = '{1'b0, 1'b0, 1'b0};
            e_hist   = '{1'b0, 1'b0, 1'b0};
        end else begin
            en_eff = e_hist[$-1];
            pulse  = a_hist[$-1] ^ a_hist[$-2];
            if (!m_active) begin
                if (en_eff) begin
                    m_active = 1'b1;
                    m_phase  = 0;
                end
            end else if (!en_eff) begin
                m_active = 1'b0;
                m_phase  = 0;
            end else begin
                m_phase = m_phase + 1;
                tick    = ((m_phase % INTERVAL) == 0);
                if (tick && !pulse) begin
                    if (m_debt == MAX_DEBT) m_ovf = 1'b1;
                    else                    m_debt = m_debt + 1;
                end else if (pulse && !tick && m_debt > 0) begin
                    m_debt = m_debt - 1;
                end
            end
            a_hist.push_back(ack_toggle);
            e_hist.push_back(enable);
            while (a_hist.size() > 3) void'(a_hist.pop_front());
            while (e_hist.size() > 3) void'(e_hist.pop_front());
        end
        e.req  = m_active && (m_debt > 0);
        e.urg  = m_active && (m_debt >= URGENT_LEVEL);
        e.ovf  = m_ovf;
        e.debt = 4'(m_debt);
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge ECLK);
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Monitor: one comparison per clock, taken on the falling edge.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge ECLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {refresh_req, refresh_urgent, overflow, debt};
                checks = checks + 1;
                if (a === e) begin
                    passed = passed + 1;
                end else begin
                    $display("FAIL outputs t=%0t: got req=%b urg=%b ovf=%b debt=%0d, want req=%b urg=%b ovf=%b debt=%0d",
                             $time, a.req, a.urg, a.ovf, a.debt, e.req, e.urg, e.ovf, e.debt);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // Reset is asserted just after a falling-edge comparison. This keeps the
    // asynchronous clear from racing an expectation already queued.
    task automatic do_reset(input bit ack_val, input bit en_val, input int ncyc);
        @(negedge ECLK);
        #1;
        refreshreset = 1'b0;
        ack_toggle   = ack_val;
        enable       = en_val;
        repeat (ncyc) @(posedge ECLK);
        #2;
        refreshreset = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge ECLK);
            #2;
        end
    endtask

    task automatic random_run(input int ncyc, input int ack_pct);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge ECLK);
            #2;
            if ($urandom_range(0, 99) < ack_pct) ack_toggle = ~ack_toggle;
            if (enable) begin
                if ($urandom_range(0, 99) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) enable = 1'b1;
            end
        end
    endtask

    initial begin
        int pcts[5];
        pcts = '{0, 12, 20, 33, 50};

        // The toggle is held high through reset, and no acks follow. The
        // debt climbs to saturation, and the next tick sets overflow.
        do_reset(1'b1, 1'b1, 3);
        idle_cycles(60);
        checks = checks + 1;
        if (debt === 4'd8) passed = passed + 1;
        else $display("FAIL saturation: debt=%0d, want 8", debt);
        checks = checks + 1;
        if (overflow === 1'b1) passed = passed + 1;
        else $display("FAIL saturation: overflow=%b, want 1", overflow);
        checks = checks + 1;
        if (refresh_urgent === 1'b1) passed = passed + 1;
        else $display("FAIL saturation: refresh_urgent=%b, want 1", refresh_urgent);
        checks = checks + 1;
        if (refresh_req === 1'b1) passed = passed + 1;
        else $display("FAIL saturation: refresh_req=%b, want 1", refresh_req);

        // After saturation, one ack lands on a tick edge.
        do_reset(1'b0, 1'b1, 2);
        idle_cycles(45);
        ack_toggle = ~ack_toggle;
        idle_cycles(4);

        // The debt builds up, then two acks follow one cycle apart.
        do_reset(1'b0, 1'b1, 1);
        idle_cycles(20);
        ack_toggle = ~ack_toggle;
        idle_cycles(1);
        ack_toggle = ~ack_toggle;
        idle_cycles(8);

        // A reset lands in the middle of a run while acks are in flight.
        do_reset(1'b0, 1'b1, 1);
        idle_cycles(30);
        ack_toggle = ~ack_toggle;
        do_reset(1'b0, 1'b1, 2);
        idle_cycles(12);

        // Randomised rounds, with a different ack rate in each round.
        for (int r = 0; r < 10; r++) begin
            do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                     $urandom_range(1, 3));
            random_run(300, pcts[r % 5]);
        end

        stim_done = 1'b1;
        repeat (3) @(negedge ECLK);
        #1;
        if ((passed != checks) || (checks == 0)) begin
            $display("FAIL summary: passed=%0d checks=%0d", passed, checks);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // A hard time limit ensures that the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: stim_done=%0b, want 1", stim_done);
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
